// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-sequencer state encodings and instruction-address constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2,
        FS_ERR  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] JUMP_MASK   = 32'hF000_0000;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for one RUN cycle; halt is resolved by the caller.
module pc_next_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        jump_reg,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic [15:0] branch_off,
    input  logic [25:0] jump_idx,
    input  logic [31:0] reg_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] br_disp;
    logic [31:0] jmp_target;

    assign pc_plus4   = pc + INSTR_BYTES;
    assign br_disp    = {{14{branch_off[15]}}, branch_off, 2'b00};
    assign jmp_target = (pc_plus4 & JUMP_MASK) | {4'b0000, jump_idx, 2'b00};

    always_comb begin
        next_pc  = pc_plus4;
        misalign = 1'b0;
        if (stall) begin
            next_pc = pc;
        end else if (jump_reg) begin
            // A misaligned register target leaves the PC where it is.
            if (reg_target[1:0] != 2'b00) begin
                next_pc  = pc;
                misalign = 1'b1;
            end else begin
                next_pc = reg_target;
            end
        end else if (jump) begin
            next_pc = jmp_target;
        end else if (branch_taken) begin
            next_pc = pc_plus4 + br_disp;
        end
    end

endmodule

// File: rtl/pc_fetch_seq.sv
// Program-counter sequencer: boot hold, sequential/redirected fetch, stall, halt/resume, misalign trap.
module pc_fetch_seq
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR  = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 2,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [15:0]      branch_off,
    input  logic             jump,
    input  logic [25:0]      jump_idx,
    input  logic             jump_reg,
    input  logic [31:0]      reg_target,
    input  logic             halt,
    input  logic             resume,
    output logic [31:0]      addr_o,
    output logic             addr_valid,
    output logic [31:0]      pc_plus4,
    output logic [1:0]       state_o,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic         misalign;
    logic         pc_load;
    logic [BW-1:0] boot_cnt;

    pc_next_calc u_calc (
        .pc           (pc),
        .stall        (stall),
        .jump_reg     (jump_reg),
        .jump         (jump),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .jump_idx     (jump_idx),
        .reg_target   (reg_target),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc),
        .misalign     (misalign)
    );

    always_comb begin
        state_nxt  = state;
        addr_valid = 1'b0;
        pc_load    = 1'b0;
        case (state)
            FS_BOOT: if (boot_cnt == BOOT_LAST) state_nxt = FS_RUN;
            FS_RUN: begin
                addr_valid = !stall;
                if (halt) begin
                    state_nxt = FS_HALT;
                end else if (!stall) begin
                    pc_load = 1'b1;
                    if (misalign) state_nxt = FS_ERR;
                end
            end
            FS_HALT: if (resume && !halt) state_nxt = FS_RUN;
            default: state_nxt = FS_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= FS_BOOT;
            pc           <= RESET_ADDR;
            boot_cnt     <= '0;
            misalign_err <= 1'b0;
            fetch_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == FS_BOOT) boot_cnt <= boot_cnt + 1'b1;
            if (pc_load) pc <= next_pc;
            if (pc_load && misalign) misalign_err <= 1'b1;
            if (addr_valid && fetch_cnt != {CNT_W{1'b1}}) fetch_cnt <= fetch_cnt + 1'b1;
        end
    end

    assign addr_o  = pc;
    assign state_o = state;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq with hand-computed expected addresses, states and counts.
module tb_pc_fetch_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_taken, jump, jump_reg, halt, resume;
    logic [15:0] branch_off;
    logic [25:0] jump_idx;
    logic [31:0] reg_target;
    logic [31:0] addr_o, pc_plus4;
    logic        addr_valid, misalign_err;
    logic [1:0]  state_o;
    logic [31:0] fetch_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    pc_fetch_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .jump         (jump),
        .jump_idx     (jump_idx),
        .jump_reg     (jump_reg),
        .reg_target   (reg_target),
        .halt         (halt),
        .resume       (resume),
        .addr_o       (addr_o),
        .addr_valid   (addr_valid),
        .pc_plus4     (pc_plus4),
        .state_o      (state_o),
        .misalign_err (misalign_err),
        .fetch_cnt    (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; branch_taken = 0; jump = 0; jump_reg = 0; halt = 0; resume = 0;
    endtask

    initial begin
        rst_n = 0; idle();
        branch_off = 16'h0; jump_idx = 26'h0; reg_target = 32'h0;
        tick(); tick();
        check("rst_addr", addr_o, 32'h0);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_valid", 32'(addr_valid), 32'd0);
        check("rst_cnt", fetch_cnt, 32'd0);
        check("rst_plus4", pc_plus4, 32'h4);
        check("rst_merr", 32'(misalign_err), 32'd0);

        rst_n = 1;
        tick();
        check("boot1_valid", 32'(addr_valid), 32'd0);
        check("boot1_state", 32'(state_o), 32'd0);
        tick();
        check("run_state", 32'(state_o), 32'd1);
        check("run_valid", 32'(addr_valid), 32'd1);
        check("seq0", addr_o, 32'h0);
        check("cnt0", fetch_cnt, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("seq_addr", addr_o, 32'(i * 4));
            check("seq_cnt", fetch_cnt, 32'(i));
        end

        // At 0x10: backward branch by -2 words -> 0x14 - 8 = 0x0C
        branch_taken = 1; branch_off = 16'hFFFE;
        tick();
        check("br_back", addr_o, 32'h0000_000C);
        idle();
        tick();
        check("seq_10", addr_o, 32'h0000_0010);
        branch_taken = 1; branch_off = 16'h0003;
        tick();
        check("br_fwd", addr_o, 32'h0000_0020);

        idle(); jump_reg = 1; reg_target = 32'h1000_0040;
        tick();
        check("jr_ok", addr_o, 32'h1000_0040);
        idle(); jump = 1; jump_idx = 26'h40; branch_taken = 1; branch_off = 16'h0003;
        tick();
        check("jump_wins", addr_o, 32'h1000_0100);
        check("cnt9", fetch_cnt, 32'd9);

        // Stall with a pending branch: nothing moves until stall drops
        idle(); stall = 1; branch_taken = 1; branch_off = 16'h0003;
        #1;
        check("stall_valid", 32'(addr_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr", addr_o, 32'h1000_0100);
            check("stall_cnt", fetch_cnt, 32'd9);
            check("stall_valid_h", 32'(addr_valid), 32'd0);
        end
        stall = 0;
        tick();
        check("br_after_stall", addr_o, 32'h1000_0110);
        check("cnt10", fetch_cnt, 32'd10);

        idle(); jump_reg = 1; reg_target = 32'hFFFF_FFFC;
        tick();
        check("top_addr", addr_o, 32'hFFFF_FFFC);
        check("top_plus4", pc_plus4, 32'h0);
        idle();
        tick();
        check("wrap", addr_o, 32'h0);
        halt = 1;
        tick();
        check("halt_state", 32'(state_o), 32'd2);
        check("halt_addr", addr_o, 32'h0);
        check("halt_valid", 32'(addr_valid), 32'd0);
        resume = 1;
        tick();
        check("halt_resume", 32'(state_o), 32'd2);
        halt = 0;
        tick();
        check("resume_state", 32'(state_o), 32'd1);
        check("resume_addr", addr_o, 32'h0);
        resume = 0;
        tick();
        check("post_resume", addr_o, 32'h4);

        jump_reg = 1; reg_target = 32'h0000_0102;
        tick();
        check("err_state", 32'(state_o), 32'd3);
        check("err_flag", 32'(misalign_err), 32'd1);
        check("err_addr", addr_o, 32'h4);
        idle(); resume = 1; jump = 1;
        tick();
        check("err_sticky", 32'(state_o), 32'd3);
        check("err_valid", 32'(addr_valid), 32'd0);
        check("err_hold", addr_o, 32'h4);
        idle(); rst_n = 0;
        tick();
        check("rerst_state", 32'(state_o), 32'd0);
        check("rerst_addr", addr_o, 32'h0);
        check("rerst_flag", 32'(misalign_err), 32'd0);
        check("rerst_cnt", fetch_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
